tone_synth: RTL and testbench

Two-channel square-wave tone generator for the audio path. It sits between `game_sound` / top-level volume logic and `speaker_control`. It takes per-channel half-period dividers plus a 0–5 volume level and a mute flag, and produces signed 16-bit left/right samples. Amplitude changes (volume steps, mute, note on/off) are slewed by a linear ramp so the speaker never sees a hard step.

---
 rtl/tone_synth_if.sv | 22 ++
 rtl/tone_synth.sv | 127 ++++++++++++
 tb/tb_tone_synth.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tone_synth_if.sv
// Control and sample bundle between the sound/volume logic and tone_synth.
// The master drives the note/volume controls; the slave (tone_synth) returns samples.
interface tone_synth_if #(
  parameter int DIV_W = 26
);
  logic [2:0]         volume;
  logic               mute;
  logic [DIV_W-1:0]   note_div_left;
  logic [DIV_W-1:0]   note_div_right;
  logic signed [15:0] audio_left;
  logic signed [15:0] audio_right;

  modport master (
    output volume, mute, note_div_left, note_div_right,
    input  audio_left, audio_right
  );

  modport slave (
    input  volume, mute, note_div_left, note_div_right,
    output audio_left, audio_right
  );
endinterface

// File: rtl/tone_synth.sv
// Two-channel square-wave tone generator with slew-limited amplitude.
// Each channel runs its own half-period oscillator; a shared tick ramps amplitude toward target.
module tone_synth #(
  parameter int DIV_W     = 26,
  parameter int MAX_DIV   = 1_000_000,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 16
) (
  input  logic         clk,
  input  logic         rst,
  tone_synth_if.slave  bus
);

  localparam int                RCNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  MAX_DIV_V = DIV_W'(MAX_DIV);
  localparam logic [14:0]       STEP      = 15'(RAMP_STEP);

  function automatic logic sounding(input logic [DIV_W-1:0] div);
    return (div != '0) && (div <= MAX_DIV_V);
  endfunction

  function automatic logic [14:0] level_amp(input logic [2:0] vol);
    case (vol)
      3'd0:    return 15'h0000;
      3'd1:    return 15'h0600;
      3'd2:    return 15'h0C00;
      3'd3:    return 15'h1800;
      3'd4:    return 15'h2400;
      default: return 15'h3000;
    endcase
  endfunction

  // Step toward the target, snapping to it once the remaining gap is under one step.
  function automatic logic [14:0] ramp_next(input logic [14:0] amp, input logic [14:0] tgt);
    if (tgt > amp)
      return ((tgt - amp) < STEP) ? tgt : amp + STEP;
    else if (amp > tgt)
      return ((amp - tgt) < STEP) ? tgt : amp - STEP;
    else
      return amp;
  endfunction

  function automatic logic signed [15:0] to_sample(input logic ph, input logic [14:0] amp);
    logic signed [15:0] mag;
    mag = signed'({1'b0, amp});
    return ph ? mag : -mag;
  endfunction

  logic [RCNT_W-1:0] r_rcnt;
  logic [DIV_W-1:0]  r_cnt_l_p0, r_cnt_r_p0;
  logic              r_ph_l_p0, r_ph_r_p0;
  logic [14:0]       r_amp_l_p0, r_amp_r_p0;

  logic              w_tick;
  logic              w_snd_l, w_snd_r;
  logic [14:0]       w_tgt_l, w_tgt_r;

  always_comb begin
    w_tick  = (r_rcnt == RCNT_LAST);
    w_snd_l = sounding(bus.note_div_left);
    w_snd_r = sounding(bus.note_div_right);
    w_tgt_l = (bus.mute || !w_snd_l) ? 15'h0000 : level_amp(bus.volume);
    w_tgt_r = (bus.mute || !w_snd_r) ? 15'h0000 : level_amp(bus.volume);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rcnt <= '0;
    else if (w_tick) r_rcnt <= '0;
    else             r_rcnt <= r_rcnt + RCNT_W'(1);
  end

  // Stage p0: oscillators and amplitude ramps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_l_p0 <= '0;
      r_ph_l_p0  <= 1'b0;
    end else if (w_snd_l) begin
      if (r_cnt_l_p0 >= bus.note_div_left - DIV_W'(1)) begin
        r_cnt_l_p0 <= '0;
        r_ph_l_p0  <= ~r_ph_l_p0;
      end else begin
        r_cnt_l_p0 <= r_cnt_l_p0 + DIV_W'(1);
      end
    end else begin
      r_cnt_l_p0 <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_r_p0 <= '0;
      r_ph_r_p0  <= 1'b0;
    end else if (w_snd_r) begin
      if (r_cnt_r_p0 >= bus.note_div_right - DIV_W'(1)) begin
        r_cnt_r_p0 <= '0;
        r_ph_r_p0  <= ~r_ph_r_p0;
      end else begin
        r_cnt_r_p0 <= r_cnt_r_p0 + DIV_W'(1);
      end
    end else begin
      r_cnt_r_p0 <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_amp_l_p0 <= '0;
      r_amp_r_p0 <= '0;
    end else if (w_tick) begin
      r_amp_l_p0 <= ramp_next(r_amp_l_p0, w_tgt_l);
      r_amp_r_p0 <= ramp_next(r_amp_r_p0, w_tgt_r);
    end
  end

  // Stage p1: registered signed samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.audio_left  <= '0;
      bus.audio_right <= '0;
    end else begin
      bus.audio_left  <= to_sample(r_ph_l_p0, r_amp_l_p0);
      bus.audio_right <= to_sample(r_ph_r_p0, r_amp_r_p0);
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed scenarios plus random segments, checked every cycle
// against a behavioural model of oscillator, target table, ramp and output sign.
module tb_tone_synth;
  localparam int DIV_W     = 26;
  localparam int MAX_DIV   = 50;
  localparam int RAMP_DIV  = 4;
  localparam int RAMP_STEP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_synth_if #(.DIV_W(DIV_W)) bus ();

  tone_synth #(
    .DIV_W(DIV_W), .MAX_DIV(MAX_DIV), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int amp_tbl [6] = '{0, 'h600, 'hC00, 'h1800, 'h2400, 'h3000};

  // Behavioural model: channel state as plain integers, rules applied per clock
  int m_cnt [2];
  int m_ph  [2];
  int m_amp [2];
  int m_aud [2];
  int m_cyc;

  always @(posedge clk or posedge rst) begin : model
    int  div, tgt, lvl, ncyc, gap;
    bit  snd, tick;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] <= 0; m_ph[c] <= 0; m_amp[c] <= 0; m_aud[c] <= 0;
      end
      m_cyc <= 0;
    end else begin
      ncyc = m_cyc + 1;
      tick = (ncyc % RAMP_DIV) == 0;
      lvl  = (bus.volume > 3'd5) ? 5 : int'(bus.volume);
      for (int c = 0; c < 2; c++) begin
        div = (c == 0) ? int'(bus.note_div_left) : int'(bus.note_div_right);
        snd = (div >= 1) && (div <= MAX_DIV);
        tgt = (bus.mute || !snd) ? 0 : amp_tbl[lvl];
        m_aud[c] <= (m_ph[c] != 0) ? m_amp[c] : -m_amp[c];
        if (snd) begin
          if (m_cnt[c] >= div - 1) begin
            m_cnt[c] <= 0;
            m_ph[c]  <= 1 - m_ph[c];
          end else begin
            m_cnt[c] <= m_cnt[c] + 1;
          end
        end else begin
          m_cnt[c] <= 0;
        end
        if (tick) begin
          gap = tgt - m_amp[c];
          if (gap < RAMP_STEP && gap > -RAMP_STEP) m_amp[c] <= tgt;
          else if (gap > 0)                        m_amp[c] <= m_amp[c] + RAMP_STEP;
          else                                     m_amp[c] <= m_amp[c] - RAMP_STEP;
        end
      end
      m_cyc <= ncyc;
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] act, exp;
    for (int c = 0; c < 2; c++) begin
      act = (c == 0) ? bus.audio_left : bus.audio_right;
      exp = 16'(m_aud[c]);
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        if (n_fail <= 30)
          $display("FAIL audio_%s at %0t: got %h, model wants %h", (c == 0) ? "left" : "right", $time, act, exp);
      end
    end
  end

  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? -v : v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DIV_W-1:0] pick_div();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return DIV_W'(1);
      2:       return DIV_W'($urandom_range(2, 12));
      3:       return DIV_W'(MAX_DIV);
      4:       return DIV_W'(MAX_DIV + 1);
      default: return '1;
    endcase
  endfunction

  initial begin : stim
    logic [15:0] a, b;
    bus.volume         = 3'd1;
    bus.mute           = 1'b0;
    bus.note_div_left  = DIV_W'(10);
    bus.note_div_right = '0;
    rst                = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_left", bus.audio_left, 16'h0000);
    check("reset_right", bus.audio_right, 16'h0000);
    rst = 1'b0;

    // first tick lands on edge 4; sample reflects it one edge later, ph still 0
    wait_cyc(4);
    check("pre_tick_left", bus.audio_left, 16'h0000);
    wait_cyc(1);
    check("first_tick_left", bus.audio_left, 16'hFFF0);
    wait_cyc(6);
    check("first_flip_left", bus.audio_left, 16'h0020);

    @(negedge clk);
    bus.volume         = 3'd5;
    bus.note_div_right = DIV_W'(1);
    wait_cyc(3300);
    a = bus.audio_right;
    wait_cyc(1);
    b = bus.audio_right;
    check("period_right_a", mag(a), 16'h3000);
    check("period_right_alt", b, -a);

    @(negedge clk);
    bus.volume = 3'd0;
    wait_cyc(3300);
    check("vol0_right", bus.audio_right, 16'h0000);
    @(negedge clk);
    bus.volume = 3'd3;
    wait_cyc(1700);
    check("vol3_right", mag(bus.audio_right), 16'h1800);
    @(negedge clk);
    bus.volume = 3'd7;
    wait_cyc(1700);
    check("vol7_clamp_right", mag(bus.audio_right), 16'h3000);

    @(negedge clk);
    bus.mute   = 1'b1;
    bus.volume = 3'd2;
    wait_cyc(3300);
    check("mute_left", bus.audio_left, 16'h0000);
    check("mute_right", bus.audio_right, 16'h0000);
    @(negedge clk);
    bus.mute = 1'b0;
    wait_cyc(1000);
    check("unmute_left", mag(bus.audio_left), 16'h0C00);

    @(negedge clk);
    bus.note_div_left = '0;
    wait_cyc(1000);
    check("rest0_left", bus.audio_left, 16'h0000);
    check("rest0_right", mag(bus.audio_right), 16'h0C00);
    @(negedge clk);
    bus.note_div_left = DIV_W'(10);
    wait_cyc(1000);
    @(negedge clk);
    bus.note_div_left = DIV_W'(MAX_DIV + 1);
    wait_cyc(1000);
    check("rest_max_left", bus.audio_left, 16'h0000);

    @(negedge clk);
    bus.note_div_left = DIV_W'(10);
    wait_cyc(1000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_left", bus.audio_left, 16'h0000);
    check("async_rst_right", bus.audio_right, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.volume         = 3'($urandom_range(0, 7));
      bus.mute           = ($urandom_range(0, 3) == 0);
      bus.note_div_left  = pick_div();
      bus.note_div_right = pick_div();
      if ($urandom_range(0, 9) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(20, 600)) @(posedge clk);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
